sram_port_arb: RTL

Two-requester arbiter and sequencer for port B of the core's byte-writable dual-port SRAM. Shares port B between the core load/store unit (m0) and the debug/DMA master (m1) with round-robin arbitration, an optional bounded burst lock for m1, and routing of the 1-cycle-latency read data back to the owning requester. Port A (instruction fetch) is untouched.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_rr_arb2.sv | 43 ++++
 rtl/sram_port_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the port-B SRAM arbiter: FSM states, read-owner tags
// and the fixed byte-lane mask width.
package sram_arb_pkg;

  localparam int WEM_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant with a last-grant register and an override that
// reserves the grant for requester 1 while a burst lock is held.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock_m1,
  output logic gnt0,
  output logic gnt1
);

  owner_e last_gnt;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_m1) begin
      gnt1 = req1;
    end else if (req0 && req1) begin
      gnt0 = (last_gnt == OWNER_M1);
      gnt1 = (last_gnt == OWNER_M0);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Reset to M1 so the first tie after reset goes to m0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= OWNER_M1;
    end else if (gnt1) begin
      last_gnt <= OWNER_M1;
    end else if (gnt0) begin
      last_gnt <= OWNER_M0;
    end
  end

endmodule

// File: rtl/sram_port_arb.sv
// Port-B sequencer for the dual-port SRAM: arbitrates m0 (LSU) against m1
// (debug/DMA) with a bounded m1 burst lock and routes read data to its owner.
module sram_port_arb
  import sram_arb_pkg::*;
#(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  output logic             m0_gnt,
  input  logic             m0_we,
  input  logic [WEM_W-1:0] m0_wem,
  input  logic [AW-1:0]    m0_addr,
  input  logic [DW-1:0]    m0_wdata,
  output logic             m0_rvld,
  output logic [DW-1:0]    m0_rdata,
  input  logic             m1_req,
  output logic             m1_gnt,
  input  logic             m1_we,
  input  logic [WEM_W-1:0] m1_wem,
  input  logic [AW-1:0]    m1_addr,
  input  logic [DW-1:0]    m1_wdata,
  output logic             m1_rvld,
  output logic [DW-1:0]    m1_rdata,
  input  logic             m1_lock,
  output logic             ram_en,
  output logic             ram_we,
  output logic [WEM_W-1:0] ram_wem,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout
);

  localparam int CW = $clog2(LOCK_MAX) + 1;

  arb_state_e    state, state_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          m0_xfer, m1_xfer;
  logic          rd_pend;
  owner_e        rd_owner;

  sram_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req0    (m0_req),
    .req1    (m1_req),
    .lock_m1 ((state == ST_LOCK) && m1_req),
    .gnt0    (m0_gnt),
    .gnt1    (m1_gnt)
  );

  assign m0_xfer = m0_req & m0_gnt;
  assign m1_xfer = m1_req & m1_gnt;

  // Lock exits on a dropped request, an unlocked beat, or the beat count cap.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ST_IDLE: begin
        if (m1_xfer && m1_lock) begin
          state_nxt    = ST_LOCK;
          lock_cnt_nxt = CW'(1);
        end
      end
      ST_LOCK: begin
        if (!m1_req) begin
          state_nxt    = ST_IDLE;
          lock_cnt_nxt = '0;
        end else begin
          if (lock_cnt != CW'(LOCK_MAX)) lock_cnt_nxt = lock_cnt + CW'(1);
          if ((lock_cnt_nxt == CW'(LOCK_MAX)) || !m1_lock) begin
            state_nxt    = ST_IDLE;
            lock_cnt_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  assign ram_en   = m0_xfer | m1_xfer;
  assign ram_we   = m1_gnt ? m1_we    : m0_we;
  assign ram_wem  = m1_gnt ? m1_wem   : m0_wem;
  assign ram_addr = m1_gnt ? m1_addr  : m0_addr;
  assign ram_din  = m1_gnt ? m1_wdata : m0_wdata;

  // SRAM read data lands one cycle after acceptance; tag it with the owner now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWNER_M0;
    end else begin
      rd_pend <= ram_en & ~ram_we;
      if (ram_en) rd_owner <= m1_gnt ? OWNER_M1 : OWNER_M0;
    end
  end

  assign m0_rvld  = rd_pend & (rd_owner == OWNER_M0);
  assign m1_rvld  = rd_pend & (rd_owner == OWNER_M1);
  assign m0_rdata = ram_dout;
  assign m1_rdata = ram_dout;

endmodule
